// File: rtl/alu_result_stage.sv
// Result stage behind the combinational ALU: a 2-entry skid buffer on the
// result/opcode/flags path plus architectural status and overflow accounting.
module alu_result_stage #(
    parameter int WIDTH     = 32,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_y,
    input  logic [3:0]           in_op,
    input  logic                 in_carry,
    input  logic                 in_overflow,
    input  logic                 in_zero,
    input  logic                 in_negative,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_y,
    output logic [3:0]           out_op,
    output logic [3:0]           out_flags,
    output logic [3:0]           status_flags,
    output logic                 sticky_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count,
    input  logic                 clr_sticky
);

    // State bits are {skid_valid, out_valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic             accept, commit;
    logic             load_out_in, load_out_skid, load_skid;
    logic [3:0]       in_flags;
    logic [WIDTH-1:0] skid_y;
    logic [3:0]       skid_op;
    logic [3:0]       skid_flags;

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign in_flags  = {in_negative, in_zero, in_carry, in_overflow};
    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept    = in_valid & in_ready;
    assign commit    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && commit) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (commit) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (commit) begin
                    load_out_skid = 1'b1;
                    state_d       = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output and skid registers: the only timing boundary between ALU and consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_y      <= '0;
            out_op     <= '0;
            out_flags  <= '0;
            skid_y     <= '0;
            skid_op    <= '0;
            skid_flags <= '0;
        end else begin
            if (load_out_in) begin
                out_y     <= in_y;
                out_op    <= in_op;
                out_flags <= in_flags;
            end else if (load_out_skid) begin
                out_y     <= skid_y;
                out_op    <= skid_op;
                out_flags <= skid_flags;
            end
            if (load_skid) begin
                skid_y     <= in_y;
                skid_op    <= in_op;
                skid_flags <= in_flags;
            end
        end
    end

    // Commit side effects; a V=1 commit wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_flags <= '0;
            sticky_ovf   <= 1'b0;
            ovf_count    <= '0;
        end else begin
            if (commit) status_flags <= out_flags;
            if (commit && out_flags[0]) begin
                sticky_ovf <= 1'b1;
                ovf_count  <= clr_sticky ? OVF_CNT_W'(1) : sat_inc(ovf_count);
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
                ovf_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted entries queue up in a model
// of the buffer contents; status and overflow accounting come from that queue.
module tb_alu_result_stage;
    localparam int W  = 32;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_y = '0;
    logic [3:0]    in_op = '0;
    logic          in_carry = 1'b0, in_overflow = 1'b0, in_zero = 1'b0, in_negative = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic [3:0]    out_op, out_flags, status_flags;
    logic          sticky_ovf;
    logic [CW-1:0] ovf_count;
    logic          clr_sticky = 1'b0;

    alu_result_stage #(.WIDTH(W), .OVF_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op),
        .in_carry(in_carry), .in_overflow(in_overflow), .in_zero(in_zero),
        .in_negative(in_negative),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
        .out_flags(out_flags), .status_flags(status_flags), .sticky_ovf(sticky_ovf),
        .ovf_count(ovf_count), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] y;
        logic [3:0]   op;
        logic [3:0]   f;
    } ent_t;

    ent_t q[$];
    logic [3:0] m_status = '0;
    logic       m_sticky = 1'b0;
    int         m_cnt = 0;
    int         vectors = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on the falling edge, then advance the model by what the
    // next rising edge will do (commit first, then accept).
    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_status = '0;
            m_sticky = 1'b0;
            m_cnt    = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_y", 64'(out_y), 64'd0);
            chk("rst_out_flags", 64'(out_flags), 64'd0);
            chk("rst_status", 64'(status_flags), 64'd0);
            chk("rst_sticky", 64'(sticky_ovf), 64'd0);
            chk("rst_ovf_count", 64'(ovf_count), 64'd0);
        end else begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_y", 64'(out_y), 64'(q[0].y));
                chk("out_op", 64'(out_op), 64'(q[0].op));
                chk("out_flags", 64'(out_flags), 64'(q[0].f));
            end
            chk("status_flags", 64'(status_flags), 64'(m_status));
            chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
            chk("ovf_count", 64'(ovf_count), 64'(m_cnt));

            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                m_status = e.f;
                if (e.f[0]) begin
                    m_sticky = 1'b1;
                    m_cnt    = clr_sticky ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
                end else if (clr_sticky) begin
                    m_sticky = 1'b0;
                    m_cnt    = 0;
                end
            end else if (clr_sticky) begin
                m_sticky = 1'b0;
                m_cnt    = 0;
            end
            if (in_valid && in_ready)
                q.push_back('{y: in_y, op: in_op, f: {in_negative, in_zero, in_carry, in_overflow}});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [W-1:0] y, input logic [3:0] op, input logic [3:0] f);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        in_y     = y;
        in_op    = op;
        {in_negative, in_zero, in_carry, in_overflow} = f;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                $display("FAIL drive_timeout: in_ready stuck at %0b, required 1", in_ready);
                $fatal(1, "handshake stalled");
            end
        end while (!acc);
        in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        #2 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // single transfer
        out_ready = 1'b1;
        drive(32'h0000_0005, 4'd0, 4'b0000);
        cyc(3);

        // back-to-back streaming
        for (int i = 0; i < 8; i++)
            drive($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & 4'b1110);
        cyc(3);

        // backpressure with three offers
        out_ready = 1'b0;
        fork
            begin
                drive(32'h1111_0001, 4'd1, 4'b0000);
                drive(32'h2222_0002, 4'd2, 4'b0100);
                drive(32'h3333_0003, 4'd3, 4'b0010);
            end
            begin
                cyc(6);
                out_ready = 1'b1;
            end
        join
        cyc(4);

        // overflow accounting and saturation
        drive(32'h8000_0000, 4'd0, 4'b1001);
        cyc(2);
        for (int i = 0; i < 5; i++)
            drive($urandom, 4'($urandom_range(0, 15)), {3'($urandom_range(0, 7)), 1'b1});
        cyc(3);

        // clear coincident with a V=1 commit, then clear alone
        drive(32'h7FFF_FFFF, 4'd4, 4'b0001);
        clr_sticky = 1'b1;
        cyc(1);
        cyc(1);
        clr_sticky = 1'b0;
        cyc(2);

        // randomized traffic with random backpressure and clears
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_y     = $urandom;
                in_op    = 4'($urandom_range(0, 15));
                {in_negative, in_zero, in_carry, in_overflow} = 4'($urandom_range(0, 15));
            end
            out_ready  = ($urandom_range(0, 2) != 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
        end
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        out_ready  = 1'b1;
        cyc(5);

        // reset while the buffer is full
        out_ready = 1'b0;
        drive(32'hAAAA_0001, 4'd5, 4'b0001);
        drive(32'hBBBB_0002, 4'd6, 4'b1000);
        cyc(1);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(5);
        drive(32'hCCCC_0003, 4'd7, 4'b0100);
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage directly after the combinational ALU.
- Registers the ALU result, opcode and flags (N, Z, C, V) behind a valid/ready handshake using a 2-entry skid buffer, which cuts the timing path between the ALU and the consumer.
- On each committed transfer it maintains an architectural status register, a sticky overflow bit and a saturating overflow counter.
- Feeds the writeback/consumer logic.

Parameters:
- WIDTH, 32, datapath width; must match the ALU width.
- OVF_CNT_W, 8, width of the saturating overflow event counter.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- in_y  input  WIDTH  ALU result
- in_op  input  4  opcode that produced the result
- in_carry  input  1  ALU carry
- in_overflow  input  1  ALU signed overflow
- in_zero  input  1  ALU zero flag
- in_negative  input  1  ALU negative flag
- out_valid  output  1  output entry valid
- out_ready  input  1  consumer accepts
- out_y  output  WIDTH  registered result
- out_op  output  4  registered opcode
- out_flags  output  4  {N,Z,C,V} of the output entry
- status_flags  output  4  {N,Z,C,V} of the last committed result
- sticky_ovf  output  1  set by any committed result with V=1
- ovf_count  output  OVF_CNT_W  saturating count of committed results with V=1
- clr_sticky  input  1  synchronous clear of sticky_ovf and ovf_count

Behaviour:
- Reset state (rst_n low, asynchronous):
  - in_ready=1, out_valid=0.
  - out_y, out_op, out_flags and the skid register: all 0.
  - status_flags=4'b0000, sticky_ovf=0, ovf_count=0.
- Handshake events:
  - accept = in_valid & in_ready.
  - commit = out_valid & out_ready.
  - in_valid is ignored when in_ready=0; the upstream holds its data.
- State machine, encoded from {skid_valid, out_valid}:
  - EMPTY: on accept, load the output register and go to ONE.
  - ONE, accept only: load the skid register, go to FULL, in_ready=0 from the next cycle.
  - ONE, commit only: go to EMPTY.
  - ONE, accept and commit in the same cycle: load the output register with the new entry and stay in ONE.
  - FULL: in_ready=0. On commit, move skid to output and go to ONE; in_ready=1 the next cycle.
- Latency: 1 cycle from accept in EMPTY to out_valid=1. Full throughput (1 per cycle) while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_y, out_op and out_flags hold constant.
- Ordering: strict FIFO order; there is never any loss or duplication.
- Commit side effects, all updated in the cycle after the commit edge:
  - status_flags <= out_flags.
  - If V=1: sticky_ovf <= 1.
  - If V=1: ovf_count <= ovf_count+1, saturating at all-ones with no wrap.
- Without a commit, status_flags holds.
- clr_sticky:
  - Without a V=1 commit: sticky_ovf <= 0 and ovf_count <= 0.
  - Same cycle as a V=1 commit: sticky_ovf <= 1 and ovf_count <= 1.
  - clr_sticky has no effect on the buffer or status_flags.
- Flags are captured as presented. The stage does not recompute Z or N from in_y.
- Reset mid-operation: entries in flight are discarded and all outputs return to their reset values immediately. No commit is generated.

Test Plan:
- Reset, then a single accept of in_y=32'h0000_0005, op=0, flags=0000 with out_ready=1:
  - out_valid=1 one cycle later with out_y=5.
  - status_flags=0000 after the commit.
- Streaming: 8 results back-to-back with out_ready=1:
  - in_ready stays 1.
  - One output per cycle in order, latency 1.
- Backpressure: out_ready=0 while 3 results are offered:
  - The first two are accepted, then in_ready=0.
  - out_y holds the first value.
  - Raising out_ready drains the entries in order and the third is accepted afterwards.
- Overflow accounting:
  - Commit 7FFF_FFFF+1 with V=1, N=1 -> sticky_ovf=1, ovf_count=1, status_flags=1001.
  - With OVF_CNT_W=2, five V=1 commits -> ovf_count=3 (saturated).
- clr_sticky in the same cycle as a V=1 commit -> sticky_ovf=1, ovf_count=1. clr_sticky alone the next cycle -> both 0.
- Assert rst_n low while in the FULL state -> out_valid=0 and in_ready=1 at once, with no further outputs after release until a new accept.
